// File: rtl/aes_stream_arbiter_if.sv
// Handshake bundle between two request channels, the arbiter
// and a shared AES core.
interface aes_stream_arbiter_if #(
  parameter int DW = 128
) ();
  logic          ch0_req;
  logic          ch0_enc;
  logic [DW-1:0] ch0_data;
  logic [DW-1:0] ch0_key;
  logic          ch0_ack;
  logic [DW-1:0] ch0_out;
  logic          ch0_out_valid;
  logic          ch0_out_ready;

  logic          ch1_req;
  logic          ch1_enc;
  logic [DW-1:0] ch1_data;
  logic [DW-1:0] ch1_key;
  logic          ch1_ack;
  logic [DW-1:0] ch1_out;
  logic          ch1_out_valid;
  logic          ch1_out_ready;

  logic [DW-1:0] aes_in;
  logic [DW-1:0] aes_key;
  logic          aes_encrypt;
  logic          aes_ready;
  logic [DW-1:0] aes_out;
  logic          aes_done;

  logic          busy;
  logic          grant_id;
  logic          timeout_err;

  modport master (
    input  ch0_req, ch0_enc, ch0_data, ch0_key, ch0_out_ready,
    input  ch1_req, ch1_enc, ch1_data, ch1_key, ch1_out_ready,
    input  aes_out, aes_done,
    output ch0_ack, ch0_out, ch0_out_valid,
    output ch1_ack, ch1_out, ch1_out_valid,
    output aes_in, aes_key, aes_encrypt, aes_ready,
    output busy, grant_id, timeout_err
  );

  modport slave (
    output ch0_req, ch0_enc, ch0_data, ch0_key, ch0_out_ready,
    output ch1_req, ch1_enc, ch1_data, ch1_key, ch1_out_ready,
    output aes_out, aes_done,
    input  ch0_ack, ch0_out, ch0_out_valid,
    input  ch1_ack, ch1_out, ch1_out_valid,
    input  aes_in, aes_key, aes_encrypt, aes_ready,
    input  busy, grant_id, timeout_err
  );
endinterface

// File: rtl/aes_stream_arbiter.sv
// Round-robin sharing of one AES core between two channels, with
// one-entry result buffers per channel and a WAIT-state watchdog.
module aes_stream_arbiter #(
  parameter int DW      = 128,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input logic           clk,
  input logic           reset,
  aes_stream_arbiter_if.master bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          prio_q, prio_d;
  logic          gid_q, gid_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          rdy_q, rdy_d;
  logic          enc_q, enc_d;
  logic [1:0]    ack_q, ack_d;
  logic [1:0]    val_q, val_d;
  logic [DW-1:0] in_q, in_d;
  logic [DW-1:0] key_q, key_d;
  logic [DW-1:0] out0_q, out0_d;
  logic [DW-1:0] out1_q, out1_d;
  logic [1:0]    req;
  logic [1:0]    rdy_in;
  logic [1:0]    elig;
  logic          sel;

  assign req    = {bus.ch1_req, bus.ch0_req};
  assign rdy_in = {bus.ch1_out_ready, bus.ch0_out_ready};
  // a full buffer blocks its channel until the consumer drains it
  assign elig   = req & ~val_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    prio_d  = prio_q;
    gid_d   = gid_q;
    err_d   = err_q;
    rdy_d   = 1'b0;
    ack_d   = 2'b00;
    enc_d   = enc_q;
    in_d    = in_q;
    key_d   = key_q;
    out0_d  = out0_q;
    out1_d  = out1_q;
    val_d   = val_q & ~rdy_in;
    sel     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (elig != 2'b00) begin
          sel        = (elig == 2'b11) ? prio_q : elig[1];
          gid_d      = sel;
          ack_d[sel] = 1'b1;
          rdy_d      = 1'b1;
          enc_d      = sel ? bus.ch1_enc  : bus.ch0_enc;
          in_d       = sel ? bus.ch1_data : bus.ch0_data;
          key_d      = sel ? bus.ch1_key  : bus.ch0_key;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.aes_done) begin
          if (gid_q) out1_d = bus.aes_out;
          else       out0_d = bus.aes_out;
          val_d[gid_q] = 1'b1;
          prio_d       = ~gid_q;
          state_d      = S_IDLE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          prio_d  = ~gid_q;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      prio_q  <= 1'b0;
      gid_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
      ack_q   <= 2'b00;
      val_q   <= 2'b00;
      enc_q   <= 1'b0;
      in_q    <= '0;
      key_q   <= '0;
      out0_q  <= '0;
      out1_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      prio_q  <= prio_d;
      gid_q   <= gid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      ack_q   <= ack_d;
      val_q   <= val_d;
      enc_q   <= enc_d;
      in_q    <= in_d;
      key_q   <= key_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
    end
  end

  assign bus.ch0_ack       = ack_q[0];
  assign bus.ch1_ack       = ack_q[1];
  assign bus.ch0_out       = out0_q;
  assign bus.ch1_out       = out1_q;
  assign bus.ch0_out_valid = val_q[0];
  assign bus.ch1_out_valid = val_q[1];
  assign bus.aes_in        = in_q;
  assign bus.aes_key       = key_q;
  assign bus.aes_encrypt   = enc_q;
  assign bus.aes_ready     = rdy_q;
  assign bus.busy          = busy_q;
  assign bus.grant_id      = gid_q;
  assign bus.timeout_err   = err_q;
endmodule

// File: tb/tb_aes_stream_arbiter.sv
// Bench for aes_stream_arbiter: stub AES core, two requesters and a
// cycle-level transaction model of grant, capture and watchdog rules.
module tb_aes_stream_arbiter;
  localparam int DW = 128;
  localparam int TO = 8;
  localparam logic [127:0] FK  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FPT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FCT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct {
    logic         enc;
    logic [127:0] data;
    logic [127:0] key;
  } job_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  aes_stream_arbiter_if #(.DW(DW)) bus ();

  aes_stream_arbiter #(.DW(DW), .TIMEOUT(TO), .TW(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  job_t         jq0[$];
  job_t         jq1[$];
  logic         req_v [2];
  logic         enc_v [2];
  logic         ordy_v[2];
  logic         ack_w [2];
  logic [127:0] dat_v [2];
  logic [127:0] key_v [2];
  int           rmode [2];

  bit           hang;
  int           late_req;
  int           late_seen = 0;
  int           core_cnt;
  bit           core_busy;
  logic [127:0] core_res;

  // model: m_since = -1 idle, 0 issue cycle, k>=1 means (k-1)th wait cycle
  int           m_since = -1;
  int           m_ch = 0;
  int           m_gid = 0;
  int           m_prio = 0;
  bit           m_err = 0;
  bit           m_full[2];
  logic [127:0] m_out [2];
  logic [127:0] m_in = '0;
  logic [127:0] m_key = '0;
  logic         m_enc = 1'b0;
  int           grants[$];
  int           pops[2];

  assign bus.ch0_req       = req_v[0];
  assign bus.ch0_enc       = enc_v[0];
  assign bus.ch0_data      = dat_v[0];
  assign bus.ch0_key       = key_v[0];
  assign bus.ch0_out_ready = ordy_v[0];
  assign bus.ch1_req       = req_v[1];
  assign bus.ch1_enc       = enc_v[1];
  assign bus.ch1_data      = dat_v[1];
  assign bus.ch1_key       = key_v[1];
  assign bus.ch1_out_ready = ordy_v[1];
  assign ack_w[0]          = bus.ch0_ack;
  assign ack_w[1]          = bus.ch1_ack;

  function automatic logic [127:0] cipher(input logic enc,
                                          input logic [127:0] d,
                                          input logic [127:0] k);
    logic [127:0] x;
    if (k == FK && enc && d == FPT) return FCT;
    if (k == FK && !enc && d == FCT) return FPT;
    x = enc ? ({d[63:0], d[127:64]} ^ k) : (d ^ k);
    return enc ? x : {x[63:0], x[127:64]};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic job_t mkjob(input logic e, input logic [127:0] d,
                                 input logic [127:0] k);
    job_t j;
    j.enc = e; j.data = d; j.key = k;
    return j;
  endfunction

  function automatic job_t rjob();
    return mkjob(1'($urandom_range(0, 1)), rnd128(), rnd128());
  endfunction

  task automatic push(input int ch, input job_t j);
    if (ch == 0) jq0.push_back(j);
    else         jq1.push_back(j);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit idle_now();
    return jq0.size() == 0 && jq1.size() == 0 && !req_v[0] && !req_v[1]
        && m_since < 0 && !m_full[0] && !m_full[1];
  endfunction

  function automatic int cnt_grants(input int s, input int ch);
    int n = 0;
    for (int i = s; i < grants.size(); i++) if (grants[i] == ch) n++;
    return n;
  endfunction

  task automatic wait_idle(input string tag, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (idle_now()) break;
      @(posedge clk); #1;
    end
    chk(tag, 128'(idle_now()), 128'd1);
  endtask

  // stub core: fixed reversible function, random latency 1..6
  always @(posedge clk) begin
    bus.aes_done <= 1'b0;
    if (late_seen != late_req) begin
      bus.aes_done <= 1'b1;
      bus.aes_out  <= rnd128();
      late_seen    <= late_req;
    end else if (reset) begin
      core_busy <= 1'b0;
    end else if (bus.aes_ready && !hang) begin
      core_busy <= 1'b1;
      core_cnt  <= $urandom_range(1, 6);
      core_res  <= cipher(bus.aes_encrypt, bus.aes_in, bus.aes_key);
    end else if (core_busy) begin
      if (core_cnt <= 1) begin
        bus.aes_done <= 1'b1;
        bus.aes_out  <= core_res;
        core_busy    <= 1'b0;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : drv
    initial begin
      job_t j;
      req_v[g] = 1'b0; enc_v[g] = 1'b0; ordy_v[g] = 1'b0;
      dat_v[g] = '0;   key_v[g] = '0;
      forever begin
        @(posedge clk); #1;
        case (rmode[g])
          0:       ordy_v[g] = 1'b0;
          1:       ordy_v[g] = 1'b1;
          default: ordy_v[g] = 1'($urandom_range(0, 1));
        endcase
        if (reset) begin
          req_v[g] = 1'b0;
        end else if (req_v[g]) begin
          if (ack_w[g]) req_v[g] = 1'b0;
        end else if ((g == 0 ? jq0.size() : jq1.size()) > 0) begin
          if (g == 0) j = jq0.pop_front();
          else        j = jq1.pop_front();
          enc_v[g] = j.enc; dat_v[g] = j.data; key_v[g] = j.key;
          req_v[g] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin : mon
    int c;
    bit e0, e1;
    if (reset) begin
      chk("rst busy", 128'(bus.busy), 0);
      chk("rst aes_ready", 128'(bus.aes_ready), 0);
      chk("rst out_valid", 128'({bus.ch1_out_valid, bus.ch0_out_valid}), 0);
      chk("rst timeout_err", 128'(bus.timeout_err), 0);
      m_since = -1; m_ch = 0; m_gid = 0; m_prio = 0; m_err = 0;
      m_full[0] = 0; m_full[1] = 0; m_out[0] = '0; m_out[1] = '0;
      m_in = '0; m_key = '0; m_enc = 1'b0;
    end else begin
      chk("busy", 128'(bus.busy), 128'(m_since >= 0));
      chk("aes_ready", 128'(bus.aes_ready), 128'(m_since == 0));
      chk("ch0_ack", 128'(bus.ch0_ack), 128'(m_since == 0 && m_ch == 0));
      chk("ch1_ack", 128'(bus.ch1_ack), 128'(m_since == 0 && m_ch == 1));
      chk("grant_id", 128'(bus.grant_id), 128'(m_gid));
      chk("aes_in", bus.aes_in, m_in);
      chk("aes_key", bus.aes_key, m_key);
      chk("aes_encrypt", 128'(bus.aes_encrypt), 128'(m_enc));
      chk("ch0_out_valid", 128'(bus.ch0_out_valid), 128'(m_full[0]));
      chk("ch1_out_valid", 128'(bus.ch1_out_valid), 128'(m_full[1]));
      chk("ch0_out", bus.ch0_out, m_out[0]);
      chk("ch1_out", bus.ch1_out, m_out[1]);
      chk("timeout_err", 128'(bus.timeout_err), 128'(m_err));
      e0 = req_v[0] && !m_full[0];
      e1 = req_v[1] && !m_full[1];
      for (int n = 0; n < 2; n++)
        if (m_full[n] && ordy_v[n]) begin m_full[n] = 0; pops[n]++; end
      if (m_since < 0) begin
        if (e0 || e1) begin
          c = (e0 && e1) ? m_prio : (e1 ? 1 : 0);
          m_ch = c; m_gid = c; m_since = 0;
          m_in = dat_v[c]; m_key = key_v[c]; m_enc = enc_v[c];
          grants.push_back(c);
        end
      end else if (m_since == 0) begin
        m_since = 1;
      end else if (bus.aes_done) begin
        m_full[m_ch] = 1;
        m_out[m_ch]  = cipher(m_enc, m_in, m_key);
        m_prio = 1 - m_ch; m_since = -1;
      end else if (m_since == TO) begin
        m_err = 1; m_prio = 1 - m_ch; m_since = -1;
      end else begin
        m_since++;
      end
    end
  end

  initial begin
    int s;
    int p0, p1;
    rmode[0] = 1; rmode[1] = 1; hang = 0; late_req = 0;
    pops[0] = 0; pops[1] = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset aes_in", bus.aes_in, '0);
    chk("reset aes_key", bus.aes_key, '0);
    chk("reset grant_id", 128'(bus.grant_id), 0);
    chk("reset ack", 128'({bus.ch1_ack, bus.ch0_ack}), 0);
    chk("reset ch0_out", bus.ch0_out, '0);
    reset = 1'b0;

    rmode[0] = 0;
    push(0, mkjob(1'b1, FPT, FK));
    for (int i = 0; i < 40 && !bus.ch0_out_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("fips enc valid", 128'(bus.ch0_out_valid), 1);
    chk("fips enc out", bus.ch0_out, FCT);
    chk("fips ch1 valid", 128'(bus.ch1_out_valid), 0);
    chk("fips ch1 out", bus.ch1_out, '0);
    rmode[0] = 1;
    wait_idle("fips enc idle", 50);

    rmode[1] = 0;
    push(1, mkjob(1'b0, FCT, FK));
    for (int i = 0; i < 40 && !bus.ch1_out_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("fips dec valid", 128'(bus.ch1_out_valid), 1);
    chk("fips dec out", bus.ch1_out, FPT);
    rmode[1] = 1;
    wait_idle("fips dec idle", 50);

    s = grants.size(); p0 = pops[0]; p1 = pops[1];
    for (int i = 0; i < 3; i++) begin
      push(0, rjob());
      push(1, rjob());
    end
    wait_idle("contention idle", 300);
    chk("contention grants", 128'(grants.size() - s), 6);
    for (int i = 0; i < 6; i++)
      if (s + i < grants.size())
        chk("contention order", 128'(grants[s + i]), 128'(i % 2));
    chk("contention pops0", 128'(pops[0] - p0), 3);
    chk("contention pops1", 128'(pops[1] - p1), 3);

    rmode[0] = 0;
    s = grants.size();
    push(0, rjob()); push(0, rjob());
    push(1, rjob()); push(1, rjob()); push(1, rjob());
    for (int i = 0; i < 200; i++) begin
      if (jq1.size() == 0 && !req_v[1] && m_since < 0) break;
      @(posedge clk); #1;
    end
    repeat (8) @(posedge clk);
    #1;
    chk("bp ch0 grants", 128'(cnt_grants(s, 0)), 1);
    chk("bp ch1 grants", 128'(cnt_grants(s, 1)), 3);
    chk("bp ch0 held", 128'(bus.ch0_out_valid), 1);
    rmode[0] = 1;
    wait_idle("bp idle", 200);
    chk("bp ch0 regrant", 128'(cnt_grants(s, 0)), 2);

    rmode[0] = 2; rmode[1] = 2;
    s = grants.size();
    for (int i = 0; i < 15; i++) begin
      push(0, rjob());
      push(1, rjob());
    end
    wait_idle("random idle", 3000);
    chk("random grants", 128'(grants.size() - s), 30);
    rmode[0] = 1; rmode[1] = 1;

    hang = 1;
    push(0, rjob());
    for (int i = 0; i < 60 && !bus.timeout_err; i++) begin
      @(posedge clk); #1;
    end
    chk("wd err", 128'(bus.timeout_err), 1);
    chk("wd no valid", 128'(bus.ch0_out_valid), 0);
    chk("wd idle", 128'(bus.busy), 0);
    hang = 0;
    s = grants.size(); p1 = pops[1];
    push(1, rjob());
    wait_idle("wd next idle", 100);
    chk("wd next grant", 128'(cnt_grants(s, 1)), 1);
    chk("wd next pop", 128'(pops[1] - p1), 1);
    chk("wd sticky", 128'(bus.timeout_err), 1);

    hang = 1;
    push(0, rjob());
    for (int i = 0; i < 30 && m_since < 3; i++) begin
      @(posedge clk); #1;
    end
    chk("rst reached wait", 128'(m_since >= 3), 1);
    #3 reset = 1'b1;
    #1;
    chk("async busy", 128'(bus.busy), 0);
    chk("async aes_ready", 128'(bus.aes_ready), 0);
    chk("async valid0", 128'(bus.ch0_out_valid), 0);
    chk("async valid1", 128'(bus.ch1_out_valid), 0);
    chk("async err", 128'(bus.timeout_err), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    hang = 0;
    late_req++;
    repeat (6) @(posedge clk);
    #1;
    chk("late done valid0", 128'(bus.ch0_out_valid), 0);
    chk("late done valid1", 128'(bus.ch1_out_valid), 0);
    chk("late done busy", 128'(bus.busy), 0);

    s = grants.size();
    push(0, rjob());
    wait_idle("post reset idle", 100);
    chk("post reset grant", 128'(cnt_grants(s, 0)), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL time limit: simulation did not complete");
    $fatal(1);
  end
endmodule
